// File: rtl/mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl_fsm
// Brief    : Multicycle MIPS control unit; sequences the shared datapath and
//            handshakes every memory access on mem_ready.
// Revision : 1.0
// ============================================================================
module mc_ctrl_fsm #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_ADDI  = 6'b001000,
  parameter logic [5:0] OP_J     = 6'b000010
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcen,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsrc,
  output logic       illegal_op
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  state_t state;
  logic   op_legal;

  assign op_legal = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
                    (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:  if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          if (op == OP_LW || op == OP_SW) state <= S_MEMADR;
          else if (op == OP_RTYPE)        state <= S_EXEC;
          else if (op == OP_BEQ)          state <= S_BRANCH;
          else if (op == OP_ADDI)         state <= S_ADDIEX;
          else if (op == OP_J)            state <= S_JUMP;
          else                            state <= S_FETCH;
        end
        S_MEMADR: state <= (op == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:  if (mem_ready) state <= S_MEMWB;
        S_MEMWB:  state <= S_FETCH;
        S_MEMWR:  if (mem_ready) state <= S_FETCH;
        S_EXEC:   state <= S_ALUWB;
        S_ALUWB:  state <= S_FETCH;
        S_BRANCH: state <= S_FETCH;
        S_ADDIEX: state <= S_ADDIWB;
        S_ADDIWB: state <= S_FETCH;
        S_JUMP:   state <= S_FETCH;
        default:  state <= S_FETCH;
      endcase
    end
  end

  // Outputs follow the state directly so reset removes every strobe at once.
  always_comb begin
    pcen       = 1'b0;
    iord       = 1'b0;
    memread    = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    aluop      = 2'b00;
    pcsrc      = 2'b00;
    illegal_op = 1'b0;
    case (state)
      S_FETCH: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        irwrite = mem_ready;
        pcen    = mem_ready;
      end
      S_DECODE: begin
        alusrcb    = 2'b11;
        illegal_op = ~op_legal;
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_EXEC: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      S_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        pcen    = zero;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_ADDIWB: begin
        regwrite = 1'b1;
      end
      S_JUMP: begin
        pcsrc = 2'b10;
        pcen  = 1'b1;
      end
      default: begin
        pcen = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_ctrl_fsm
// Brief    : Self-checking bench: instruction-step model plus directed checks.
// Revision : 1.0
// ============================================================================
module tb_mc_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic       pcen, iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite;
  logic       alusrca, illegal_op;
  logic [1:0] alusrcb, aluop, pcsrc;

  int vectors = 0;
  int miscompares = 0;

  mc_ctrl_fsm dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pcen(pcen), .iord(iord), .memread(memread), .memwrite(memwrite),
    .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg),
    .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .aluop(aluop), .pcsrc(pcsrc), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  // Instruction step kinds; an instruction is a list of these.
  localparam int K_FETCH = 0, K_DECODE = 1, K_ADDR = 2, K_LOAD = 3, K_LOADWB = 4,
                 K_STORE = 5, K_ALU = 6, K_ALUWB = 7, K_BEQ = 8, K_ADDI = 9,
                 K_ADDIWB = 10, K_JUMP = 11;

  int plan[$];
  int pos;

  function automatic logic legal(input logic [5:0] o);
    return o == 6'b000000 || o == 6'b100011 || o == 6'b101011 ||
           o == 6'b000100 || o == 6'b001000 || o == 6'b000010;
  endfunction

  // Packed order: pcen iord memread memwrite irwrite regdst memtoreg regwrite
  //               alusrca alusrcb aluop pcsrc illegal_op
  function automatic logic [16:0] expect_word(input int k, input logic mr,
                                              input logic z, input logic [5:0] o);
    logic pe, io, rd, wr, ir, rdst, m2r, rw, sa, ill;
    logic [1:0] sb, ao, ps;
    {pe, io, rd, wr, ir, rdst, m2r, rw, sa, ill} = '0;
    sb = 2'b00; ao = 2'b00; ps = 2'b00;
    case (k)
      K_FETCH:  begin rd = 1; sb = 2'b01; ir = mr; pe = mr; end
      K_DECODE: begin sb = 2'b11; ill = !legal(o); end
      K_ADDR:   begin sa = 1; sb = 2'b10; end
      K_LOAD:   begin rd = 1; io = 1; end
      K_LOADWB: begin m2r = 1; rw = 1; end
      K_STORE:  begin io = 1; wr = 1; end
      K_ALU:    begin sa = 1; ao = 2'b10; end
      K_ALUWB:  begin rdst = 1; rw = 1; end
      K_BEQ:    begin sa = 1; ao = 2'b01; ps = 2'b01; pe = z; end
      K_ADDI:   begin sa = 1; sb = 2'b10; end
      K_ADDIWB: begin rw = 1; end
      K_JUMP:   begin ps = 2'b10; pe = 1; end
      default:  ;
    endcase
    return {pe, io, rd, wr, ir, rdst, m2r, rw, sa, sb, ao, ps, ill};
  endfunction

  function automatic logic waits(input int k);
    return k == K_FETCH || k == K_LOAD || k == K_STORE;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      plan = '{K_FETCH, K_DECODE};
      pos  = 0;
    end else begin
      if (!(waits(plan[pos]) && !mem_ready)) begin
        if (plan[pos] == K_DECODE) begin
          case (op)
            6'b100011: begin plan.push_back(K_ADDR); plan.push_back(K_LOAD); plan.push_back(K_LOADWB); end
            6'b101011: begin plan.push_back(K_ADDR); plan.push_back(K_STORE); end
            6'b000000: begin plan.push_back(K_ALU);  plan.push_back(K_ALUWB); end
            6'b000100: plan.push_back(K_BEQ);
            6'b001000: begin plan.push_back(K_ADDI); plan.push_back(K_ADDIWB); end
            6'b000010: plan.push_back(K_JUMP);
            default: ;
          endcase
        end
        pos++;
        if (pos >= plan.size()) begin
          plan = '{K_FETCH, K_DECODE};
          pos  = 0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [16:0] act, input logic [16:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h, required %h", name, $time, act, req);
    end
  endtask

  logic [16:0] dut_word;
  assign dut_word = {pcen, iord, memread, memwrite, irwrite, regdst, memtoreg,
                     regwrite, alusrca, alusrcb, aluop, pcsrc, illegal_op};

  always @(negedge clk) begin
    if (plan.size() > 0)
      check("model", dut_word, expect_word(plan[pos], mem_ready, zero, op));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From a FETCH cycle: run one instruction, stalling MEMRD `stalls` cycles.
  task automatic run_instr(input logic [5:0] o, input logic z, input int stalls,
                           output int cycles, output int n_rw, output int n_mw,
                           output int n_ill, output int n_brpc, output int n_m2r);
    int s;
    s = stalls;
    cycles = 0; n_rw = 0; n_mw = 0; n_ill = 0; n_brpc = 0; n_m2r = 0;
    op = o; zero = z; mem_ready = 1'b1;
    #1;
    check("fetch_go", {15'd0, irwrite, pcen}, {15'd0, 2'b11});
    forever begin
      tick();
      cycles++;
      if (memread && iord && s > 0) begin
        mem_ready = 1'b0;
        s--;
      end else begin
        mem_ready = 1'b1;
      end
      #1;
      if (irwrite) break;
      n_rw   += int'(regwrite);
      n_mw   += int'(memwrite);
      n_ill  += int'(illegal_op);
      n_brpc += int'(pcen && pcsrc == 2'b01);
      n_m2r  += int'(memtoreg && regwrite);
      if (cycles > 50) begin
        check("timeout", 17'(cycles), 17'd0);
        break;
      end
    end
  endtask

  initial begin
    int c, rw, mw, il, bp, m2r;
    rst_n = 1'b0; op = 6'b000000; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) tick();
    check("reset_strobes", {12'd0, pcen, irwrite, memwrite, regwrite, illegal_op}, 17'd0);
    check("reset_selects", {9'd0, iord, alusrcb, aluop, pcsrc, alusrca}, {9'd0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0});
    rst_n = 1'b1;
    repeat (3) begin
      tick();
      check("fetch_hold", {16'd0, irwrite}, 17'd0);
    end

    run_instr(6'b000000, 1'b0, 0, c, rw, mw, il, bp, m2r);
    check("rtype_cycles", 17'(c), 17'd4);
    check("rtype_regwrite", 17'(rw), 17'd1);
    run_instr(6'b100011, 1'b0, 2, c, rw, mw, il, bp, m2r);
    check("lw_cycles", 17'(c), 17'd7);
    check("lw_memtoreg", 17'(m2r), 17'd1);
    run_instr(6'b101011, 1'b0, 0, c, rw, mw, il, bp, m2r);
    check("sw_cycles", 17'(c), 17'd4);
    check("sw_memwrite", 17'(mw), 17'd1);
    run_instr(6'b001000, 1'b0, 0, c, rw, mw, il, bp, m2r);
    check("addi_cycles", 17'(c), 17'd4);
    run_instr(6'b000100, 1'b1, 0, c, rw, mw, il, bp, m2r);
    check("beq_taken_cycles", 17'(c), 17'd3);
    check("beq_taken_pcen", 17'(bp), 17'd1);
    run_instr(6'b000100, 1'b0, 0, c, rw, mw, il, bp, m2r);
    check("beq_nottaken_pcen", 17'(bp), 17'd0);
    run_instr(6'b000010, 1'b0, 0, c, rw, mw, il, bp, m2r);
    check("j_cycles", 17'(c), 17'd3);
    run_instr(6'b111111, 1'b0, 0, c, rw, mw, il, bp, m2r);
    check("illegal_cycles", 17'(c), 17'd2);
    check("illegal_pulse", 17'(il), 17'd1);
    check("illegal_writes", 17'(rw + mw), 17'd0);

    // Store interrupted by reset while waiting on memory.
    op = 6'b101011;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    #1;
    check("sw_wait_memwrite", {16'd0, memwrite}, 17'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_memwrite_drop", {14'd0, memwrite, memread, iord}, {14'd0, 3'b010});
    tick();
    rst_n = 1'b1;
    repeat (3) begin
      tick();
      check("post_rst_no_write", {15'd0, memwrite, regwrite}, 17'd0);
    end

    for (int i = 0; i < 3000; i++) begin
      tick();
      rst_n     = ($urandom_range(0, 199) != 0);
      mem_ready = ($urandom_range(0, 9) < 7);
      zero      = 1'($urandom_range(0, 1));
      if (pos == 0) begin
        case ($urandom_range(0, 6))
          0: op = 6'b000000;
          1: op = 6'b100011;
          2: op = 6'b101011;
          3: op = 6'b000100;
          4: op = 6'b001000;
          5: op = 6'b000010;
          default: op = 6'($urandom);
        endcase
      end
    end
    rst_n = 1'b1;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
